// File: rtl/mf_clken_multi.sv
`default_nettype none
// ============================================================================
// mf_clken_multi : multi-channel fractional clock-enable generator with lock
// Rev 1.0
// ============================================================================
module mf_clken_multi #(
  parameter int                       NUM_CH    = 3,
  parameter int                       ACC_W     = 32,
  parameter int                       LOCK_CNT  = 4,
  parameter logic [NUM_CH*ACC_W-1:0]  DEF_INC   = '0,
  parameter logic [NUM_CH*ACC_W-1:0]  DEF_PHASE = '0,
  parameter logic [NUM_CH-1:0]        DEF_EN    = '1,
  localparam int                      CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic              cfg_en,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] ph,
  output logic              locked
);

  localparam int              LC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_CNT);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_APPLY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              locked_q, locked_d;
  logic              accept;
  logic              apply;
  logic [NUM_CH-1:0] ch_ok;

  // cfg_ready_q is only ever high in RUN, so an accept implies RUN.
  assign accept = cfg_valid & cfg_ready_q;
  assign apply  = (state_q == ST_APPLY);

  always_comb begin
    state_d     = ST_RUN;
    if (!apply && accept) begin
      state_d = ST_APPLY;
    end
    cfg_ready_d = (state_d == ST_RUN);
    locked_d    = (state_q == ST_RUN) && !accept && (&ch_ok);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      cfg_ready_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      locked_q    <= locked_d;
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign locked    = locked_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] phase_q, phase_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             en_q, en_d;
    logic             ce_q, ce_d;
    logic [LC_W-1:0]  lc_q, lc_d;
    logic             active;
    logic             wr;
    logic [ACC_W:0]   sum;

    assign active = en_q && (inc_q != '0);
    assign wr     = accept && (cfg_ch == CH_W'(i));
    assign sum    = {1'b0, acc_q} + {1'b0, inc_q};

    always_comb begin
      inc_d   = wr ? cfg_inc   : inc_q;
      phase_d = wr ? cfg_phase : phase_q;
      en_d    = wr ? cfg_en    : en_q;
      acc_d   = acc_q;
      ce_d    = 1'b0;
      lc_d    = lc_q;
      // APPLY reloads every channel together so relative phases are kept.
      if (apply) begin
        acc_d = phase_q;
        lc_d  = '0;
      end else begin
        if (active) begin
          acc_d = sum[ACC_W-1:0];
          ce_d  = sum[ACC_W];
        end
        if (ce_q && (lc_q != LC_MAX)) begin
          lc_d = lc_q + LC_W'(1);
        end
      end
    end

    always_ff @(posedge refclk) begin
      if (rst) begin
        inc_q   <= DEF_INC[i*ACC_W +: ACC_W];
        phase_q <= DEF_PHASE[i*ACC_W +: ACC_W];
        en_q    <= DEF_EN[i];
        acc_q   <= DEF_PHASE[i*ACC_W +: ACC_W];
        ce_q    <= 1'b0;
        lc_q    <= '0;
      end else begin
        inc_q   <= inc_d;
        phase_q <= phase_d;
        en_q    <= en_d;
        acc_q   <= acc_d;
        ce_q    <= ce_d;
        lc_q    <= lc_d;
      end
    end

    assign ch_ok[i] = !active || (lc_q == LC_MAX);
    assign ce[i]    = ce_q;
    assign ph[i]    = acc_q[ACC_W-1];
  end

endmodule
`default_nettype wire

// File: tb/tb_mf_clken_multi.sv
`default_nettype none
// Bench for mf_clken_multi: closed-form rate model compared every cycle,
// plus directed literal expectations taken from hand-worked timing.
module tb_mf_clken_multi;

  localparam int          NCH   = 3;
  localparam int          W     = 8;
  localparam int          L     = 4;
  localparam logic [23:0] D_INC = {8'd32, 8'd32, 8'd64};
  localparam logic [23:0] D_PH  = {8'd128, 8'd0, 8'd0};

  logic       refclk = 1'b0;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [7:0] cfg_phase;
  logic       cfg_en;
  logic [2:0] ce;
  logic [2:0] ph;
  logic       locked;

  always #5 refclk = ~refclk;

  mf_clken_multi #(
    .NUM_CH   (NCH),
    .ACC_W    (W),
    .LOCK_CNT (L),
    .DEF_INC  (D_INC),
    .DEF_PHASE(D_PH),
    .DEF_EN   (3'b111)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .cfg_phase(cfg_phase),
    .cfg_en   (cfg_en),
    .ce       (ce),
    .ph       (ph),
    .locked   (locked)
  );

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: each channel's output after n edges since reload is the closed
  // form (P + n*I) mod 2^W; pulses are carries of that sum.
  int         m_p [NCH];
  int         m_i [NCH];
  bit         m_en[NCH];
  int         m_n     = 0;
  bit         m_apply = 1'b0;
  bit         m_ready = 1'b0;
  bit         m_locked = 1'b0;
  bit         m_take;
  bit         m_ok;
  logic [2:0] m_ce = '0;
  logic [2:0] m_ph = '0;

  function automatic bit act(input int c);
    return m_en[c] && (m_i[c] != 0);
  endfunction

  function automatic longint carries(input int c, input longint k);
    if (k <= 0) return 0;
    return (longint'(m_p[c]) + k * longint'(m_i[c])) >> W;
  endfunction

  task automatic upd_out();
    longint tot;
    for (int c = 0; c < NCH; c++) begin
      tot     = act(c) ? longint'(m_p[c]) + longint'(m_n) * longint'(m_i[c]) : longint'(m_p[c]);
      m_ph[c] = tot[W-1];
      m_ce[c] = act(c) && (m_n > 0) && (carries(c, m_n) > carries(c, m_n - 1));
    end
  endtask

  always @(posedge refclk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_p[c]  = int'(D_PH[c*W +: W]);
        m_i[c]  = int'(D_INC[c*W +: W]);
        m_en[c] = 1'b1;
      end
      m_n = 0; m_apply = 1'b0; m_ready = 1'b0; m_locked = 1'b0;
      upd_out();
    end else if (m_apply) begin
      m_apply = 1'b0; m_n = 0; m_ready = 1'b1; m_locked = 1'b0;
      upd_out();
    end else begin
      m_take = cfg_valid && m_ready;
      m_ok   = 1'b1;
      for (int c = 0; c < NCH; c++)
        if (act(c) && carries(c, m_n - 1) < L) m_ok = 1'b0;
      m_locked = m_ok && !m_take;
      m_n++;
      upd_out();
      if (m_take) begin
        if (cfg_ch < 2'd3) begin
          m_i[cfg_ch]  = int'(cfg_inc);
          m_p[cfg_ch]  = int'(cfg_phase);
          m_en[cfg_ch] = cfg_en;
        end
        m_apply = 1'b1;
        m_ready = 1'b0;
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  always @(negedge refclk) begin
    if (chk_on) begin
      check("ce_vs_model", 32'(ce), 32'(m_ce));
      check("ph_vs_model", 32'(ph), 32'(m_ph));
      check("locked_vs_model", 32'(locked), 32'(m_locked));
      check("ready_vs_model", 32'(cfg_ready), 32'(m_ready));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Returns at the negedge following the accept edge.
  task automatic cfg_write(input logic [1:0] ch, input logic [7:0] inc,
                           input logic [7:0] phs, input logic en);
    int k;
    k = 0;
    cfg_ch = ch; cfg_inc = inc; cfg_phase = phs; cfg_en = en; cfg_valid = 1'b1;
    while (!m_ready && k < 10) begin
      @(negedge refclk);
      k++;
    end
    check("ready_before_accept", 32'(cfg_ready), 32'd1);
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  // Default-configuration timing measured from the first edge with rst low.
  task automatic check_defaults();
    for (int j = 0; j <= 33; j++) begin
      @(negedge refclk);
      if (j == 0) begin
        check("ph_after_R", 32'(ph), 32'b100);
        check("ready_after_R", 32'(cfg_ready), 32'd1);
      end
      if (j == 3)  check("ce_R3", 32'(ce), 32'b101);
      if (j == 7)  check("ce_R7", 32'(ce), 32'b011);
      if (j == 32) check("locked_R32", 32'(locked), 32'd0);
      if (j == 33) check("locked_R33", 32'(locked), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"}, 32'(ce), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_ready"}, 32'(cfg_ready), 32'd0);
  endtask

  logic [7:0] fr_ce = 8'b1010_0100;
  logic [7:0] fr_ph = 8'b0101_1010;

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_inc = '0; cfg_phase = '0; cfg_en = 1'b0;
    @(negedge refclk);
    chk_on = 1'b1;
    @(negedge refclk);
    check_reset_outputs("reset");
    check("reset_ph", 32'(ph), 32'b100);
    rst = 1'b0;
    check_defaults();

    // Fractional rate on ch0
    cfg_write(2'd0, 8'd96, 8'd0, 1'b1);
    check("frac_ready_T", 32'(cfg_ready), 32'd0);
    check("frac_locked_T", 32'(locked), 32'd0);
    @(negedge refclk);
    check("frac_ce_apply", 32'(ce), 32'd0);
    check("frac_ready_A", 32'(cfg_ready), 32'd1);
    for (int n = 1; n <= 8; n++) begin
      @(negedge refclk);
      check("frac_ce0", 32'(ce[0]), 32'(fr_ce[n-1]));
      check("frac_ph0", 32'(ph[0]), 32'(fr_ph[n-1]));
    end
    cyc(80);
    check("frac_locked", 32'(locked), 32'd1);

    // Reconfigure ch1 while locked
    cfg_write(2'd1, 8'd128, 8'd0, 1'b1);
    check("recfg_ready_T", 32'(cfg_ready), 32'd0);
    check("recfg_locked_T", 32'(locked), 32'd0);
    @(negedge refclk);
    check("recfg_ce_apply", 32'(ce), 32'd0);
    @(negedge refclk);
    check("recfg_ce1_n1", 32'(ce[1]), 32'd0);
    @(negedge refclk);
    check("recfg_ce1_n2", 32'(ce[1]), 32'd1);
    cyc(80);
    check("recfg_locked", 32'(locked), 32'd1);

    // Back-to-back: valid held three cycles, second data must win
    cfg_ch = 2'd1; cfg_inc = 8'd64; cfg_phase = 8'd0; cfg_en = 1'b1; cfg_valid = 1'b1;
    @(negedge refclk);
    check("b2b_ready_T", 32'(cfg_ready), 32'd0);
    cfg_inc = 8'd16; cfg_phase = 8'd64;
    @(negedge refclk);
    check("b2b_ready_T1", 32'(cfg_ready), 32'd1);
    @(negedge refclk);
    check("b2b_ready_T2", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    @(negedge refclk);
    check("b2b_ce_apply", 32'(ce), 32'd0);
    for (int n = 1; n <= 12; n++) begin
      @(negedge refclk);
      if (n == 11) check("b2b_ce1_n11", 32'(ce[1]), 32'd0);
      if (n == 12) check("b2b_ce1_n12", 32'(ce[1]), 32'd1);
    end

    // Out-of-range channel: restart only
    cfg_write(2'd3, 8'hFF, 8'hFF, 1'b0);
    @(negedge refclk);
    check("ch3_ce_apply", 32'(ce), 32'd0);
    cyc(80);
    check("ch3_locked", 32'(locked), 32'd1);

    // Inactive ch2: disabled, then zero increment
    cfg_write(2'd2, 8'd32, 8'd128, 1'b0);
    cyc(81);
    check("inact_en_locked", 32'(locked), 32'd1);
    check("inact_en_ph2", 32'(ph[2]), 32'd1);
    cfg_write(2'd2, 8'd0, 8'd128, 1'b1);
    cyc(81);
    check("inact_inc_locked", 32'(locked), 32'd1);
    check("inact_inc_ph2", 32'(ph[2]), 32'd1);

    // Reset during APPLY
    cfg_write(2'd0, 8'd64, 8'd0, 1'b1);
    rst = 1'b1;
    @(negedge refclk);
    check_reset_outputs("rst_apply");
    rst = 1'b0;
    check_defaults();

    // Reset during RUN with pulses in flight
    cyc(5);
    rst = 1'b1;
    @(negedge refclk);
    check_reset_outputs("rst_run");
    rst = 1'b0;
    check_defaults();

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
